// File: rtl/fetch_stage_pkg.sv
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared CPU constants for the instruction-fetch stage: the
//                nop encoding, the default reset PC, the per-cycle fetch
//                operation type and a word-alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  // Encoding inserted into IF/ID on a flush or a wait bubble.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  // Default address of the first instruction fetched after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // What the fetch stage does in a given cycle, in priority order.
  typedef enum logic [1:0] {
    FETCH_HOLD     = 2'd0,  // stall: everything holds
    FETCH_REDIRECT = 2'd1,  // branch/jump: load target, flush IF/ID
    FETCH_BUBBLE   = 2'd2,  // memory not ready: PC holds, bubble into IF/ID
    FETCH_ADVANCE  = 2'd3   // normal sequential fetch
  } fetch_op_e;

  // Instructions are word aligned, so the low two address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage : fetch_stage_pkg

`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
// ============================================================================
//  Module      : ifid_reg
//  Description : IF/ID pipeline register. Flush (when enabled) loads a nop
//                bubble; enable alone loads the fetched instruction and marks
//                it valid; with enable low the register holds.
//  Ports       : clk, rst_n (async active-low)
//                en         - load enable (low while the pipeline stalls)
//                flush      - load a bubble instead of the fetched word
//                instr_i    - fetched instruction word
//                pcplus4_i  - address of the fetched word plus 4
//                instr_o, pcplus4_o, valid_o - registered IF/ID contents
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q,   instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q,   valid_d;

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (en) begin
      if (flush) begin
        instr_d   = NOP_INSTR;
        pcplus4_d = 32'h0000_0000;
        valid_d   = 1'b0;
      end else begin
        instr_d   = instr_i;
        pcplus4_d = pcplus4_i;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule : ifid_reg

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage: program counter with stall,
//                branch/jump redirect and memory-wait handling, the IF/ID
//                register, and a counter of instructions delivered into IF/ID.
//  Ports       : CLK, CLRN (async active-low reset)
//                STALL                        - hold PC and IF/ID
//                BRANCH_TAKEN, BRANCH_TARGET  - taken branch redirect
//                JUMP, JUMP_TARGET            - jump redirect (wins over branch)
//                IMEM_ADDR                    - instruction address (= PC)
//                IMEM_RDATA, IMEM_READY       - instruction word and its valid
//                INSTRD, PCPLUS4D, VALIDD     - IF/ID contents
//                FETCH_CNT                    - delivered-instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [31:0]      BRANCH_TARGET,
  input  logic             JUMP,
  input  logic [31:0]      JUMP_TARGET,
  output logic [31:0]      IMEM_ADDR,
  input  logic [31:0]      IMEM_RDATA,
  input  logic             IMEM_READY,
  output logic [31:0]      INSTRD,
  output logic [31:0]      PCPLUS4D,
  output logic             VALIDD,
  output logic [CNT_W-1:0] FETCH_CNT
);

  // Even a misaligned RESET_PC parameter yields a word-aligned PC.
  localparam logic [31:0] RESET_PC_ALIGNED = align_word(RESET_PC);

  logic [31:0]      pc_q,  pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fetch_op_e   fetch_op;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        ifid_en;
  logic        ifid_flush;

  // Stall beats redirect (the hazard unit re-presents a held redirect),
  // redirect beats a memory wait (the wrong-path word is discarded anyway).
  always_comb begin
    if (STALL) begin
      fetch_op = FETCH_HOLD;
    end else if (BRANCH_TAKEN || JUMP) begin
      fetch_op = FETCH_REDIRECT;
    end else if (!IMEM_READY) begin
      fetch_op = FETCH_BUBBLE;
    end else begin
      fetch_op = FETCH_ADVANCE;
    end
  end

  always_comb begin
    pc_plus4        = pc_q + 32'd4;  // wraps naturally at 2^32
    redirect_target = JUMP ? JUMP_TARGET : BRANCH_TARGET;
    pc_d            = pc_q;
    cnt_d           = cnt_q;
    unique case (fetch_op)
      FETCH_REDIRECT: pc_d = align_word(redirect_target);
      FETCH_ADVANCE: begin
        pc_d  = pc_plus4;
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;  // HOLD and BUBBLE keep the PC and the count
    endcase
  end

  assign ifid_en    = (fetch_op != FETCH_HOLD);
  assign ifid_flush = (fetch_op == FETCH_REDIRECT) || (fetch_op == FETCH_BUBBLE);

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      pc_q  <= RESET_PC_ALIGNED;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk       (CLK),
    .rst_n     (CLRN),
    .en        (ifid_en),
    .flush     (ifid_flush),
    .instr_i   (IMEM_RDATA),
    .pcplus4_i (pc_plus4),
    .instr_o   (INSTRD),
    .pcplus4_o (PCPLUS4D),
    .valid_o   (VALIDD)
  );

  assign IMEM_ADDR = pc_q;
  assign FETCH_CNT = cnt_q;

endmodule : fetch_stage

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. A second
//                instance with RESET_PC=32'hFFFF_FFFC and a 2-bit counter
//                free-runs with IMEM_READY=1 to cover PC and counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        CLK;
  logic        CLRN;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        JUMP;
  logic [31:0] JUMP_TARGET;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_READY;
  logic [31:0] INSTRD;
  logic [31:0] PCPLUS4D;
  logic        VALIDD;
  logic [31:0] FETCH_CNT;

  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic [1:0]  w_cnt;

  int checks = 0;
  int errors = 0;

  fetch_stage u_dut (
    .CLK           (CLK),
    .CLRN          (CLRN),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .JUMP          (JUMP),
    .JUMP_TARGET   (JUMP_TARGET),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_RDATA    (IMEM_RDATA),
    .IMEM_READY    (IMEM_READY),
    .INSTRD        (INSTRD),
    .PCPLUS4D      (PCPLUS4D),
    .VALIDD        (VALIDD),
    .FETCH_CNT     (FETCH_CNT)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_dut_wrap (
    .CLK           (CLK),
    .CLRN          (CLRN),
    .STALL         (1'b0),
    .BRANCH_TAKEN  (1'b0),
    .BRANCH_TARGET (32'h0),
    .JUMP          (1'b0),
    .JUMP_TARGET   (32'h0),
    .IMEM_ADDR     (w_addr),
    .IMEM_RDATA    (32'h1234_5678),
    .IMEM_READY    (1'b1),
    .INSTRD        (w_instr),
    .PCPLUS4D      (w_pc4),
    .VALIDD        (w_valid),
    .FETCH_CNT     (w_cnt)
  );

  // Instruction memory: three program words, every other address returns
  // 32'hAC00_0000 | address.
  always_comb begin
    case (IMEM_ADDR)
      32'h0:   IMEM_RDATA = 32'h2008_0005;
      32'h4:   IMEM_RDATA = 32'h2009_0003;
      32'h8:   IMEM_RDATA = 32'h0109_5020;
      default: IMEM_RDATA = 32'hAC00_0000 | IMEM_ADDR;
    endcase
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
    check_val({tag, ".pc"},    IMEM_ADDR, pc);
    check_val({tag, ".instr"}, INSTRD,    instr);
    check_val({tag, ".pc4"},   PCPLUS4D,  pc4);
    check_val({tag, ".valid"}, {31'b0, VALIDD}, {31'b0, valid});
    check_val({tag, ".cnt"},   FETCH_CNT, cnt);
  endtask

  initial begin
    CLRN          = 1'b0;
    STALL         = 1'b0;
    BRANCH_TAKEN  = 1'b0;
    BRANCH_TARGET = 32'h0;
    JUMP          = 1'b0;
    JUMP_TARGET   = 32'h0;
    IMEM_READY    = 1'b1;

    // Reset state.
    #22;
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check_val("wrap.reset_pc", w_addr, 32'hFFFF_FFFC);
    CLRN = 1'b1;

    // Three sequential fetches from address 0.
    tick();
    check_ifid("fetch1", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'd1);
    check_val("wrap.pc1",  w_addr, 32'h0);
    check_val("wrap.pc4a", w_pc4,  32'h0);
    tick();
    check_ifid("fetch2", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 32'd2);
    tick();
    check_ifid("fetch3", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 32'd3);
    check_val("wrap.cnt3", {30'b0, w_cnt}, 32'd3);

    // Jump back to 0x8 with misaligned low bits, then a two-cycle memory wait.
    JUMP = 1'b1; JUMP_TARGET = 32'h0000_000B;
    tick();
    check_ifid("jump8", 32'h8, 32'h0, 32'h0, 1'b0, 32'd3);
    check_val("wrap.cnt_wrap", {30'b0, w_cnt}, 32'd0);
    JUMP = 1'b0; IMEM_READY = 1'b0;
    tick();
    check_ifid("wait1", 32'h8, 32'h0, 32'h0, 1'b0, 32'd3);
    tick();
    check_ifid("wait2", 32'h8, 32'h0, 32'h0, 1'b0, 32'd3);
    IMEM_READY = 1'b1;
    tick();
    check_ifid("waitdone", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 32'd4);
    tick();
    check_ifid("to10", 32'h10, 32'hAC00_000C, 32'h10, 1'b1, 32'd5);

    // Taken branch at PC=0x10 to 0x40 (low bits of target discarded).
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h0000_0043;
    tick();
    check_ifid("branch", 32'h40, 32'h0, 32'h0, 1'b0, 32'd5);
    BRANCH_TAKEN = 1'b0;

    // Reach PC=0x20 with a valid word in IF/ID, then stall with a jump pending.
    JUMP = 1'b1; JUMP_TARGET = 32'h1C;
    tick();
    JUMP = 1'b0;
    tick();
    check_ifid("at20", 32'h20, 32'hAC00_001C, 32'h20, 1'b1, 32'd6);
    STALL = 1'b1; JUMP = 1'b1; JUMP_TARGET = 32'h100;
    tick();
    check_ifid("stall1", 32'h20, 32'hAC00_001C, 32'h20, 1'b1, 32'd6);
    tick();
    check_ifid("stall2", 32'h20, 32'hAC00_001C, 32'h20, 1'b1, 32'd6);
    STALL = 1'b0;
    tick();
    check_ifid("unstall", 32'h100, 32'h0, 32'h0, 1'b0, 32'd6);

    // Jump and branch together, memory not ready: jump target wins.
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h200; JUMP_TARGET = 32'h300; IMEM_READY = 1'b0;
    tick();
    check_ifid("both", 32'h300, 32'h0, 32'h0, 1'b0, 32'd6);
    BRANCH_TAKEN = 1'b0; IMEM_READY = 1'b1;

    // Reach PC=0x50 with a valid word, stall, then reset asynchronously.
    JUMP_TARGET = 32'h4C;
    tick();
    JUMP = 1'b0;
    tick();
    check_ifid("at50", 32'h50, 32'hAC00_004C, 32'h50, 1'b1, 32'd7);
    STALL = 1'b1;
    tick();
    #2;
    CLRN = 1'b0;
    #1;
    check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check_val("wrap.async_rst", w_addr, 32'hFFFF_FFFC);
    STALL = 1'b0;
    @(negedge CLK);
    CLRN = 1'b1;
    tick();
    check_ifid("refetch", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
Parameters (name, default, meaning):
REQ-001 RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 CNT_W, 32, width of the delivered-instruction counter.
Ports (name, direction, width, meaning):
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 CLRN  in  1  reset, asynchronous, active-low.
REQ-005 STALL  in  1  hazard-unit hold request for the PC and the IF/ID register.
REQ-006 BRANCH_TAKEN  in  1  ID-stage branch resolved taken (beq/bne).
REQ-007 BRANCH_TARGET  in  32  branch destination address.
REQ-008 JUMP  in  1  ID-stage j/jal decoded.
REQ-009 JUMP_TARGET  in  32  jump destination address.
REQ-010 IMEM_ADDR  out  32  instruction-memory address, equal to PC.
REQ-011 IMEM_RDATA  in  32  instruction word, combinational read of IMEM_ADDR.
REQ-012 IMEM_READY  in  1  IMEM_RDATA valid this cycle.
REQ-013 INSTRD  out  32  IF/ID instruction; bits [31:26] feed the main decoder OP input.
REQ-014 PCPLUS4D  out  32  IF/ID PC+4, used for branch target and the jal link.
REQ-015 VALIDD  out  1  IF/ID contains a real instruction.
REQ-016 FETCH_CNT  out  CNT_W  count of instructions delivered into IF/ID.

Function
REQ-017 Redirect is BRANCH_TAKEN or JUMP; when both are high, JUMP_TARGET SHALL win.
REQ-018 Priority per cycle: STALL, then redirect, then IMEM_READY low, then normal advance.
REQ-019 STALL high: PC, INSTRD, PCPLUS4D, VALIDD and FETCH_CNT hold; redirect is ignored, and the hazard unit re-presents it.
REQ-020 Redirect with STALL low: PC loads the target; IF/ID loads INSTRD=32'h0 (nop), PCPLUS4D=0, VALIDD=0 (flush of the wrong-path fetch), whatever the state of IMEM_READY.
REQ-021 IMEM_READY low, no STALL, no redirect: PC holds; IF/ID loads a bubble (INSTRD=0, VALIDD=0).
REQ-022 Normal advance: PC loads PC+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0); INSTRD loads IMEM_RDATA; PCPLUS4D loads PC+4; VALIDD loads 1; FETCH_CNT increments.
REQ-023 FETCH_CNT SHALL wrap from all-ones to 0 and increment only on a normal advance.
REQ-024 PC[1:0] SHALL always be 0; the low two bits of any target are discarded.
REQ-025 Latency: an instruction at address A appears on INSTRD one cycle after IMEM_ADDR=A with IMEM_READY=1.
REQ-026 IMEM_ADDR SHALL be driven combinationally from the PC register.

Reset
REQ-027 CLRN low SHALL immediately force PC=RESET_PC, INSTRD=0, PCPLUS4D=0, VALIDD=0 and FETCH_CNT=0, including mid-stall or mid-wait.
REQ-028 On the first edge after CLRN rises, the block SHALL perform a normal fetch from RESET_PC if IMEM_READY is 1.

Structure
REQ-029 NOP_INSTR (32'h0) and the default RESET_PC SHALL live in the shared CPU constants package.
REQ-030 The IF/ID register SHALL be a sub-module ifid_reg with enable (not STALL) and flush inputs; PC logic and the counter stay in fetch_stage.

Verification
REQ-031 Reset, then IMEM_READY=1 for 3 cycles returning 0x20080005, 0x20090003, 0x01095020 -> IMEM_ADDR 0, 4, 8; INSTRD follows one cycle later; PCPLUS4D 4, 8, 12; FETCH_CNT=3.
REQ-032 At PC=0x10, BRANCH_TAKEN=1 with BRANCH_TARGET=0x40 -> next PC=0x40, VALIDD=0, INSTRD=0, FETCH_CNT unchanged.
REQ-033 At PC=0x20, STALL=1 and JUMP=1 with JUMP_TARGET=0x100 -> PC stays 0x20 and IF/ID holds; after STALL drops with JUMP still high, PC=0x100.
REQ-034 At PC=0x8, IMEM_READY=0 for 2 cycles -> PC stays 0x8, two bubbles with VALIDD=0; READY=1 then delivers the word at 0x8.
REQ-035 JUMP and BRANCH_TAKEN both high, targets 0x200 and 0x300 -> PC=0x300; separately, RESET_PC=32'hFFFF_FFFC -> second fetch address 0.
REQ-036 Assert CLRN low asynchronously mid-stall at PC=0x50 -> outputs reach reset values before the next CLK edge.
